// File: rtl/ps2mouse_cfg_ctrlmod.sv
// ---------------------------------------------------------------------------
// ps2mouse_cfg_ctrlmod
//
// Host-side bring-up sequencer for a PS/2 mouse. After iStart it walks a
// small command ROM, handing each byte to a byte-level transmit engine and
// checking the mouse's replies from the byte receiver. The sequence is reset,
// self-test (0xAA) check, device ID capture, sample rate, resolution and
// stream enable. oRdEn is raised only after the whole sequence completes
// cleanly, which lets the streaming packet reader run.
//
// Optional build macro: PS2MOUSE_INTELLI_EN
//   When defined, the wheel-unlock sequence (F3 C8, F3 64, F3 50) and a
//   second ID read (F2) are inserted after the self-test. The second ID
//   overwrites oDevId (0x03 identifies a wheel mouse).
//
// Ports:
//   CLOCK     in   system clock
//   RST       in   synchronous reset, active-high
//   iStart    in   one-cycle pulse, starts/restarts bring-up when not busy
//   oTxReq    out  one-cycle request to the transmit engine
//   oTxByte   out  byte to transmit, held from oTxReq until iTxDone
//   iTxDone   in   one-cycle pulse, transmit finished
//   iTxErr    in   one-cycle pulse, transmit failed
//   iRxTrig   in   one-cycle pulse, iRxByte valid
//   iRxByte   in   received byte
//   oRdEn     out  level, enables the streaming packet reader
//   oBusy     out  level, sequence in progress
//   oDone     out  one-cycle pulse on successful completion
//   oErr      out  level, sequence failed (held until iStart or RST)
//   oErrCode  out  failure cause
//   oDevId    out  captured device ID byte
// ---------------------------------------------------------------------------
module ps2mouse_cfg_ctrlmod #(
   parameter logic [7:0]  SAMPLE_RATE = 8'd100,
   parameter logic [7:0]  RESOLUTION  = 8'd2,
   parameter logic [23:0] ACK_TIMEOUT = 24'd1_000_000,
   parameter logic [27:0] BAT_TIMEOUT = 28'd50_000_000,
   parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
   input  logic       CLOCK,
   input  logic       RST,
   input  logic       iStart,
   output logic       oTxReq,
   output logic [7:0] oTxByte,
   input  logic       iTxDone,
   input  logic       iTxErr,
   input  logic       iRxTrig,
   input  logic [7:0] iRxByte,
   output logic       oRdEn,
   output logic       oBusy,
   output logic       oDone,
   output logic       oErr,
   output logic [3:0] oErrCode,
   output logic [7:0] oDevId
);

`ifdef PS2MOUSE_INTELLI_EN
   localparam logic [3:0] ROM_LAST = 4'd12;
   // ROM index of the F2 (read ID) command, answered by FA then an ID byte
   localparam logic [3:0] ID_IDX   = 4'd7;
`else
   localparam logic [3:0] ROM_LAST = 4'd5;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_SEND, S_WAIT_TX, S_WAIT_ACK, S_WAIT_BAT,
      S_WAIT_ID, S_RETRY, S_NEXT, S_DONE, S_FAIL
   } state_t;

   state_t      state;
   logic [3:0]  idx;
   logic [1:0]  retry_cnt;
   logic        resend_cause;   // 1: last retry was caused by a 0xFE reply
   logic [27:0] timer;
   logic        ack_expired;
   logic        bat_expired;

   assign ack_expired = (timer >= {4'd0, ACK_TIMEOUT});
   assign bat_expired = (timer >= BAT_TIMEOUT);

   // Timer saturates instead of wrapping so a long stall cannot fake a fresh count
   function automatic logic [27:0] sat_inc(input logic [27:0] t);
      return (t == 28'hFFF_FFFF) ? t : t + 28'd1;
   endfunction

   function automatic logic [7:0] rom_byte(input logic [3:0] i);
      logic [7:0] b;
      case (i)
`ifdef PS2MOUSE_INTELLI_EN
         4'd0:    b = 8'hFF;
         4'd1:    b = 8'hF3;
         4'd2:    b = 8'hC8;
         4'd3:    b = 8'hF3;
         4'd4:    b = 8'h64;
         4'd5:    b = 8'hF3;
         4'd6:    b = 8'h50;
         4'd7:    b = 8'hF2;
         4'd8:    b = 8'hF3;
         4'd9:    b = SAMPLE_RATE;
         4'd10:   b = 8'hE8;
         4'd11:   b = RESOLUTION;
         4'd12:   b = 8'hF4;
`else
         4'd0:    b = 8'hFF;
         4'd1:    b = 8'hF3;
         4'd2:    b = SAMPLE_RATE;
         4'd3:    b = 8'hE8;
         4'd4:    b = RESOLUTION;
         4'd5:    b = 8'hF4;
`endif
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   always_ff @(posedge CLOCK) begin
      if (RST) begin
         state        <= S_IDLE;
         idx          <= 4'd0;
         retry_cnt    <= 2'd0;
         resend_cause <= 1'b0;
         timer        <= 28'd0;
         oTxReq       <= 1'b0;
         oTxByte      <= 8'h00;
         oRdEn        <= 1'b0;
         oBusy        <= 1'b0;
         oDone        <= 1'b0;
         oErr         <= 1'b0;
         oErrCode     <= 4'd0;
         oDevId       <= 8'h00;
      end else begin
         oTxReq <= 1'b0;
         oDone  <= 1'b0;
         timer  <= sat_inc(timer);

         case (state)
            S_IDLE: begin
               if (iStart) begin
                  idx       <= 4'd0;
                  retry_cnt <= 2'd0;
                  oBusy     <= 1'b1;
                  state     <= S_LOAD;
               end
            end

            S_LOAD: begin
               oTxByte <= rom_byte(idx);
               timer   <= 28'd0;
               state   <= S_SEND;
            end

            // Also reached from RETRY, so the timer is cleared here too
            S_SEND: begin
               oTxReq <= 1'b1;
               timer  <= 28'd0;
               state  <= S_WAIT_TX;
            end

            // A transmit error outranks a simultaneous done
            S_WAIT_TX: begin
               if (iTxErr) begin
                  resend_cause <= 1'b0;
                  state        <= S_RETRY;
               end else if (iTxDone) begin
                  timer <= 28'd0;
                  state <= S_WAIT_ACK;
               end else if (ack_expired) begin
                  resend_cause <= 1'b0;
                  state        <= S_RETRY;
               end
            end

            // A received byte outranks a timeout in the same cycle
            S_WAIT_ACK: begin
               if (iRxTrig) begin
                  case (iRxByte)
                     8'hFA: begin
                        timer <= 28'd0;
                        if (idx == 4'd0) begin
                           state <= S_WAIT_BAT;
`ifdef PS2MOUSE_INTELLI_EN
                        end else if (idx == ID_IDX) begin
                           state <= S_WAIT_ID;
`endif
                        end else begin
                           state <= S_NEXT;
                        end
                     end
                     8'hFE: begin
                        resend_cause <= 1'b1;
                        state        <= S_RETRY;
                     end
                     8'hFC: begin
                        oErr     <= 1'b1;
                        oErrCode <= 4'd3;
                        oBusy    <= 1'b0;
                        state    <= S_FAIL;
                     end
                     default: begin
                        oErr     <= 1'b1;
                        oErrCode <= 4'd4;
                        oBusy    <= 1'b0;
                        state    <= S_FAIL;
                     end
                  endcase
               end else if (ack_expired) begin
                  resend_cause <= 1'b0;
                  state        <= S_RETRY;
               end
            end

            // Self-test can take hundreds of ms; unrelated bytes are skipped
            S_WAIT_BAT: begin
               if (iRxTrig) begin
                  if (iRxByte == 8'hAA) begin
                     timer <= 28'd0;
                     state <= S_WAIT_ID;
                  end else if (iRxByte == 8'hFC) begin
                     oErr     <= 1'b1;
                     oErrCode <= 4'd5;
                     oBusy    <= 1'b0;
                     state    <= S_FAIL;
                  end
               end else if (bat_expired) begin
                  oErr     <= 1'b1;
                  oErrCode <= 4'd6;
                  oBusy    <= 1'b0;
                  state    <= S_FAIL;
               end
            end

            S_WAIT_ID: begin
               if (iRxTrig) begin
                  oDevId <= iRxByte;
                  state  <= S_NEXT;
               end else if (ack_expired) begin
                  oErr     <= 1'b1;
                  oErrCode <= 4'd7;
                  oBusy    <= 1'b0;
                  state    <= S_FAIL;
               end
            end

            S_RETRY: begin
               if (retry_cnt == MAX_RETRY) begin
                  oErr     <= 1'b1;
                  oErrCode <= resend_cause ? 4'd2 : 4'd1;
                  oBusy    <= 1'b0;
                  state    <= S_FAIL;
               end else begin
                  retry_cnt <= retry_cnt + 2'd1;
                  state     <= S_SEND;
               end
            end

            S_NEXT: begin
               retry_cnt <= 2'd0;
               if (idx == ROM_LAST) begin
                  oDone <= 1'b1;
                  oRdEn <= 1'b1;
                  oBusy <= 1'b0;
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 4'd1;
                  state <= S_LOAD;
               end
            end

            S_DONE: begin
               if (iStart) begin
                  oRdEn     <= 1'b0;
                  oBusy     <= 1'b1;
                  idx       <= 4'd0;
                  retry_cnt <= 2'd0;
                  state     <= S_LOAD;
               end
            end

            S_FAIL: begin
               oRdEn <= 1'b0;
               if (iStart) begin
                  oErr      <= 1'b0;
                  oErrCode  <= 4'd0;
                  oBusy     <= 1'b1;
                  idx       <= 4'd0;
                  retry_cnt <= 2'd0;
                  state     <= S_LOAD;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
